// File: rtl/control_unit_pipe_pkg.sv
// Shared encodings for the pipelined RV32I control unit: opcodes, control
// field encodings, branch funct3 codes and the registered control word.
package control_unit_pipe_pkg;

    // Major opcodes recognised by the main decoder
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_LUI   = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // Control word carried from D into the ID/EX register
    typedef struct packed {
        result_src_e result_src;
        logic        mem_write;
        logic        reg_write;
        logic        jmp;
        logic        branch;
        logic        jalr;
        alu_op_e     alu_op;
        logic        alu_src;
        logic [2:0]  funct3;
        logic        valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_unit_pipe_main_decoder.sv
// Combinational RV32I main decoder: opcode (and branch funct3) to control
// word, extender select and illegal-instruction flag. Shared with the
// single-cycle variants, so it holds no state.
module control_unit_pipe_main_decoder
    import control_unit_pipe_pkg::*;
#(
    parameter bit FULL_BRANCH = 1'b1
) (
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_valid,
    output ctrl_t      o_ctrl,
    output logic [2:0] o_imm_src,
    output logic       o_illegal
);

    ctrl_t    w_ctrl;
    imm_src_e w_imm_src;
    logic     w_bad;

    // Decode opcode into control fields; unknown opcodes and reserved
    // branch funct3 codes collapse to an all-zero word.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_ctrl    = CTRL_BUBBLE;
        w_imm_src = IMM_I;
        w_bad     = 1'b0;
        case (i_opcode)
            OP_R: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                w_ctrl.result_src = RES_MEM;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
            end
            OP_ALUI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
            end
            OP_JALR: begin
                w_ctrl.result_src = RES_PC4;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.jmp        = 1'b1;
                w_ctrl.jalr       = 1'b1;
                w_ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm_src        = IMM_S;
            end
            OP_JAL: begin
                w_ctrl.result_src = RES_PC4;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.jmp        = 1'b1;
                w_imm_src         = IMM_J;
            end
            OP_B: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALU_SUB;
                w_ctrl.funct3 = i_funct3;
                w_imm_src     = IMM_B;
                // funct3 010/011 are unassigned branch encodings
                if (FULL_BRANCH && (i_funct3 == 3'b010 || i_funct3 == 3'b011)) begin
                    w_bad = 1'b1;
                end
            end
            OP_LUI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_LUI;
                w_ctrl.alu_src   = 1'b1;
                w_imm_src        = IMM_U;
            end
            default: w_bad = 1'b1;
        endcase

        if (w_bad) begin
            w_ctrl    = CTRL_BUBBLE;
            w_imm_src = IMM_I;
        end
        w_ctrl.valid = i_valid & ~w_bad;
    end

    assign o_ctrl    = w_ctrl;
    assign o_imm_src = w_imm_src;
    assign o_illegal = i_valid & w_bad;

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: decodes in D, carries the control word through
// ID/EX, EX/MEM and MEM/WB honouring stall/flush, resolves redirects in E
// and counts instructions retiring from W.
module control_unit_pipe
    import control_unit_pipe_pkg::*;
#(
    parameter bit FULL_BRANCH = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_opcode_d,
    input  logic [2:0]       i_funct3_d,
    input  logic             i_valid_d,
    input  logic             i_stall_e,
    input  logic             i_flush_e,
    input  logic             i_zero_e,
    input  logic             i_lt_e,
    input  logic             i_ltu_e,
    output logic [2:0]       o_imm_src_d,
    output logic             o_illegal_d,
    output logic [1:0]       o_alu_op_e,
    output logic             o_alu_src_e,
    output logic             o_jalr_e,
    output logic             o_pc_src_e,
    output logic             o_mem_write_m,
    output logic [1:0]       o_result_src_m,
    output logic             o_reg_write_m,
    output logic [1:0]       o_result_src_w,
    output logic             o_reg_write_w,
    output logic             o_valid_w,
    output logic [CNT_W-1:0] o_retired
);

    ctrl_t            w_ctrl_d;
    ctrl_t            r_e;
    logic [1:0]       r_m_result_src;
    logic             r_m_mem_write;
    logic             r_m_reg_write;
    logic             r_m_valid;
    logic [1:0]       r_w_result_src;
    logic             r_w_reg_write;
    logic             r_w_valid;
    logic [CNT_W-1:0] r_retired;
    logic             w_taken;

    control_unit_pipe_main_decoder #(
        .FULL_BRANCH (FULL_BRANCH)
    ) u_main_decoder (
        .i_opcode  (i_opcode_d),
        .i_funct3  (i_funct3_d),
        .i_valid   (i_valid_d),
        .o_ctrl    (w_ctrl_d),
        .o_imm_src (o_imm_src_d),
        .o_illegal (o_illegal_d)
    );

    // ID/EX register: flush beats stall, stall holds the current word
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (i_rst || i_flush_e) begin
            r_e <= CTRL_BUBBLE;
        end else if (!i_stall_e) begin
            r_e <= w_ctrl_d;
        end
    end

    // EX/MEM register: a stalled E feeds a bubble so the held op is not duplicated
    always_ff @(posedge i_clk) begin
        if (i_rst || i_stall_e) begin
            r_m_result_src <= 2'b00;
            r_m_mem_write  <= 1'b0;
            r_m_reg_write  <= 1'b0;
            r_m_valid      <= 1'b0;
        end else begin
            r_m_result_src <= r_e.result_src;
            r_m_mem_write  <= r_e.mem_write;
            r_m_reg_write  <= r_e.reg_write;
            r_m_valid      <= r_e.valid;
        end
    end

    // MEM/WB register: always advances
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_w_result_src <= 2'b00;
            r_w_reg_write  <= 1'b0;
            r_w_valid      <= 1'b0;
        end else begin
            r_w_result_src <= r_m_result_src;
            r_w_reg_write  <= r_m_reg_write;
            r_w_valid      <= r_m_valid;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retired <= '0;
        end else if (r_w_valid) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Branch condition from the latched funct3 and the E-stage ALU flags
    always_comb begin
        w_taken = i_zero_e;
        if (FULL_BRANCH) begin
            case (r_e.funct3)
                F3_BEQ:  w_taken = i_zero_e;
                F3_BNE:  w_taken = ~i_zero_e;
                F3_BLT:  w_taken = i_lt_e;
                F3_BGE:  w_taken = ~i_lt_e;
                F3_BLTU: w_taken = i_ltu_e;
                F3_BGEU: w_taken = ~i_ltu_e;
                default: w_taken = 1'b0;
            endcase
        end
    end

    assign o_pc_src_e     = r_e.valid & (r_e.jmp | (r_e.branch & w_taken));
    assign o_alu_op_e     = r_e.alu_op;
    assign o_alu_src_e    = r_e.alu_src;
    assign o_jalr_e       = r_e.jalr;
    assign o_mem_write_m  = r_m_mem_write;
    assign o_result_src_m = r_m_result_src;
    assign o_reg_write_m  = r_m_reg_write;
    assign o_result_src_w = r_w_result_src;
    assign o_reg_write_w  = r_w_reg_write;
    assign o_valid_w      = r_w_valid;
    assign o_retired      = r_retired;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Self-checking bench for control_unit_pipe. A full-branch instance with a
// 4-bit counter is the main target; a beq-only instance shares its inputs.
module tb_control_unit_pipe;

    localparam int CNT_W = 4;

    localparam logic [6:0] R    = 7'h33;
    localparam logic [6:0] LW   = 7'h03;
    localparam logic [6:0] ADDI = 7'h13;
    localparam logic [6:0] JALR = 7'h67;
    localparam logic [6:0] SW   = 7'h23;
    localparam logic [6:0] JAL  = 7'h6F;
    localparam logic [6:0] BR   = 7'h63;
    localparam logic [6:0] LUI  = 7'h37;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       valid_d = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;

    logic [2:0]       imm_src_d, nb_imm_src_d;
    logic             illegal_d, nb_illegal_d;
    logic [1:0]       alu_op_e, nb_alu_op_e;
    logic             alu_src_e, nb_alu_src_e;
    logic             jalr_e, nb_jalr_e;
    logic             pc_src_e, nb_pc_src_e;
    logic             mem_write_m, nb_mem_write_m;
    logic [1:0]       result_src_m, nb_result_src_m;
    logic             reg_write_m, nb_reg_write_m;
    logic [1:0]       result_src_w, nb_result_src_w;
    logic             reg_write_w, nb_reg_write_w;
    logic             valid_w, nb_valid_w;
    logic [CNT_W-1:0] retired, nb_retired;

    control_unit_pipe #(.FULL_BRANCH(1'b1), .CNT_W(CNT_W)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_opcode_d(opcode), .i_funct3_d(funct3),
        .i_valid_d(valid_d), .i_stall_e(stall), .i_flush_e(flush),
        .i_zero_e(zero), .i_lt_e(lt), .i_ltu_e(ltu),
        .o_imm_src_d(imm_src_d), .o_illegal_d(illegal_d), .o_alu_op_e(alu_op_e),
        .o_alu_src_e(alu_src_e), .o_jalr_e(jalr_e), .o_pc_src_e(pc_src_e),
        .o_mem_write_m(mem_write_m), .o_result_src_m(result_src_m),
        .o_reg_write_m(reg_write_m), .o_result_src_w(result_src_w),
        .o_reg_write_w(reg_write_w), .o_valid_w(valid_w), .o_retired(retired)
    );

    control_unit_pipe #(.FULL_BRANCH(1'b0), .CNT_W(CNT_W)) u_dut_nb (
        .i_clk(clk), .i_rst(rst), .i_opcode_d(opcode), .i_funct3_d(funct3),
        .i_valid_d(valid_d), .i_stall_e(stall), .i_flush_e(flush),
        .i_zero_e(zero), .i_lt_e(lt), .i_ltu_e(ltu),
        .o_imm_src_d(nb_imm_src_d), .o_illegal_d(nb_illegal_d), .o_alu_op_e(nb_alu_op_e),
        .o_alu_src_e(nb_alu_src_e), .o_jalr_e(nb_jalr_e), .o_pc_src_e(nb_pc_src_e),
        .o_mem_write_m(nb_mem_write_m), .o_result_src_m(nb_result_src_m),
        .o_reg_write_m(nb_reg_write_m), .o_result_src_w(nb_result_src_w),
        .o_reg_write_w(nb_reg_write_w), .o_valid_w(nb_valid_w), .o_retired(nb_retired)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected control for one opcode on the full-branch decoder
    typedef struct packed {
        logic       legal;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       jalr;
        logic [2:0] imm;
    } exp_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wrec_t;

    wrec_t sb_q[$];
    logic  e_has = 1'b0;
    wrec_t e_rec = '0;

    function automatic exp_t expect_of(input logic [6:0] op, input logic [2:0] f3);
        exp_t x;
        x = '0;
        x.legal = 1'b1;
        case (op)
            R:    begin x.reg_write = 1; x.alu_op = 2'b10; end
            LW:   begin x.result_src = 2'b01; x.reg_write = 1; x.alu_src = 1; end
            ADDI: begin x.reg_write = 1; x.alu_src = 1; end
            JALR: begin x.result_src = 2'b10; x.reg_write = 1; x.jalr = 1; x.alu_src = 1; end
            SW:   begin x.mem_write = 1; x.alu_src = 1; x.imm = 3'b001; end
            JAL:  begin x.result_src = 2'b10; x.reg_write = 1; x.imm = 3'b011; end
            BR:   begin
                if (f3 == 3'b010 || f3 == 3'b011) x.legal = 0;
                else begin x.alu_op = 2'b01; x.imm = 3'b010; end
            end
            LUI:  begin x.reg_write = 1; x.alu_op = 2'b11; x.alu_src = 1; x.imm = 3'b100; end
            default: x.legal = 0;
        endcase
        if (!x.legal) x = '0;
        return x;
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic v);
        opcode  = op;
        funct3  = f3;
        valid_d = v;
    endtask

    task automatic idle();
        drive(7'h00, 3'b000, 1'b0);
    endtask

    // One clock edge; the scoreboard learns what leaves E at this edge
    task automatic tick();
        exp_t x;
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
            e_has = 1'b0;
        end else begin
            if (!stall && e_has) sb_q.push_back(e_rec);
            if (flush) begin
                e_has = 1'b0;
            end else if (!stall) begin
                x = expect_of(opcode, funct3);
                e_has = valid_d & x.legal;
                e_rec = '{reg_write: x.reg_write, result_src: x.result_src};
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // Every instruction leaving W must match the oldest expected entry
    always @(negedge clk) begin
        wrec_t r;
        if (valid_w) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL w_retire: valid_w=1 with no expected instruction");
            end else begin
                r = sb_q.pop_front();
                if (reg_write_w !== r.reg_write || (r.reg_write && result_src_w !== r.result_src)) begin
                    n_err++;
                    $display("FAIL w_retire: got rw=%b rs=%b, want rw=%b rs=%b",
                             reg_write_w, result_src_w, r.reg_write, r.result_src);
                end
            end
        end
    end

    task automatic test_reset();
        logic [13:0] regs;
        rst = 1'b1;
        drive(R, 3'b000, 1'b1);
        tick();
        tick();
        regs = {alu_op_e, alu_src_e, jalr_e, pc_src_e, mem_write_m, result_src_m,
                reg_write_m, result_src_w, reg_write_w, valid_w, 1'b0};
        n_vec++;
        if (regs !== 14'd0) begin n_err++; $display("FAIL reset_regs: got %h want 0", regs); end
        n_vec++;
        if (retired !== 4'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired); end
        drive(SW, 3'b000, 1'b1);
        #1;
        n_vec++;
        if (imm_src_d !== 3'b001) begin n_err++; $display("FAIL reset_decode_imm: got %b want 001", imm_src_d); end
        idle();
        rst = 1'b0;
    endtask

    task automatic test_decode_table();
        logic [6:0] ops [8];
        exp_t x;
        ops = '{R, LW, ADDI, JALR, SW, JAL, BR, LUI};
        do_reset();
        zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = expect_of(ops[i], 3'b000);
            drive(ops[i], 3'b000, 1'b1);
            #1;
            n_vec++;
            if (imm_src_d !== x.imm || illegal_d !== 1'b0) begin
                n_err++;
                $display("FAIL decode_d op=%h: got imm=%b ill=%b want imm=%b ill=0", ops[i], imm_src_d, illegal_d, x.imm);
            end
            tick();
            n_vec++;
            if (alu_op_e !== x.alu_op || alu_src_e !== x.alu_src || jalr_e !== x.jalr) begin
                n_err++;
                $display("FAIL decode_e op=%h: got aop=%b asrc=%b jalr=%b want aop=%b asrc=%b jalr=%b",
                         ops[i], alu_op_e, alu_src_e, jalr_e, x.alu_op, x.alu_src, x.jalr);
            end
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_stream();
        do_reset();
        drive(R, 3'b000, 1'b1);   tick();
        drive(LW, 3'b010, 1'b1);  tick();
        drive(SW, 3'b010, 1'b1);  tick();
        drive(JAL, 3'b000, 1'b1); tick();
        n_vec++;
        if (pc_src_e !== 1'b1 || mem_write_m !== 1'b1) begin
            n_err++;
            $display("FAIL stream_jal_sw: got pc_src=%b mem_write_m=%b want 1 1", pc_src_e, mem_write_m);
        end
        idle();
        tick(); tick();
        n_vec++;
        if (retired !== 4'd3) begin n_err++; $display("FAIL stream_retired3: got %0d want 3", retired); end
        tick();
        n_vec++;
        if (retired !== 4'd4) begin n_err++; $display("FAIL stream_retired4: got %0d want 4", retired); end
    endtask

    task automatic test_branch();
        do_reset();
        // BNE not-equal: taken on full decoder, beq-only instance sees zero=0
        drive(BR, 3'b001, 1'b1); zero = 1'b0; tick();
        n_vec++;
        if (pc_src_e !== 1'b1 || nb_pc_src_e !== 1'b0) begin
            n_err++; $display("FAIL bne_zero0: got full=%b beq=%b want 1 0", pc_src_e, nb_pc_src_e);
        end
        drive(BR, 3'b001, 1'b1); zero = 1'b1; tick();
        n_vec++;
        if (pc_src_e !== 1'b0 || nb_pc_src_e !== 1'b1) begin
            n_err++; $display("FAIL bne_zero1: got full=%b beq=%b want 0 1", pc_src_e, nb_pc_src_e);
        end
        drive(BR, 3'b100, 1'b1); zero = 1'b0; lt = 1'b1; ltu = 1'b0; tick();
        n_vec++;
        if (pc_src_e !== 1'b1) begin n_err++; $display("FAIL blt_taken: got %b want 1", pc_src_e); end
        drive(BR, 3'b111, 1'b1); lt = 1'b0; ltu = 1'b1; tick();
        n_vec++;
        if (pc_src_e !== 1'b0) begin n_err++; $display("FAIL bgeu_not_taken: got %b want 0", pc_src_e); end
        drive(BR, 3'b101, 1'b1); lt = 1'b0; tick();
        n_vec++;
        if (pc_src_e !== 1'b1) begin n_err++; $display("FAIL bge_taken: got %b want 1", pc_src_e); end
        // Reserved funct3: illegal only when full branch decode is enabled
        drive(BR, 3'b010, 1'b1); zero = 1'b1; ltu = 1'b0;
        #1;
        n_vec++;
        if (illegal_d !== 1'b1 || nb_illegal_d !== 1'b0) begin
            n_err++; $display("FAIL br_f3_010_illegal: got full=%b beq=%b want 1 0", illegal_d, nb_illegal_d);
        end
        tick();
        n_vec++;
        if (pc_src_e !== 1'b0 || alu_op_e !== 2'b00) begin
            n_err++; $display("FAIL br_f3_010_e: got pc_src=%b aop=%b want 0 00", pc_src_e, alu_op_e);
        end
        zero = 1'b0;
        idle();
        repeat (4) tick();
    endtask

    task automatic test_illegal();
        do_reset();
        drive(7'h7F, 3'b000, 1'b0);
        #1;
        n_vec++;
        if (illegal_d !== 1'b0) begin n_err++; $display("FAIL illegal_gated: got %b want 0", illegal_d); end
        drive(7'h7F, 3'b000, 1'b1);
        #1;
        n_vec++;
        if (illegal_d !== 1'b1 || imm_src_d !== 3'b000) begin
            n_err++; $display("FAIL illegal_d: got ill=%b imm=%b want 1 000", illegal_d, imm_src_d);
        end
        zero = 1'b1;
        tick();
        idle();
        n_vec++;
        if ({alu_op_e, alu_src_e, jalr_e, pc_src_e} !== 5'd0) begin
            n_err++; $display("FAIL illegal_e: got %b want 00000", {alu_op_e, alu_src_e, jalr_e, pc_src_e});
        end
        tick();
        n_vec++;
        if ({mem_write_m, result_src_m, reg_write_m} !== 4'd0) begin
            n_err++; $display("FAIL illegal_m: got %b want 0000", {mem_write_m, result_src_m, reg_write_m});
        end
        tick();
        n_vec++;
        if ({result_src_w, reg_write_w, valid_w} !== 4'd0) begin
            n_err++; $display("FAIL illegal_w: got %b want 0000", {result_src_w, reg_write_w, valid_w});
        end
        tick();
        n_vec++;
        if (retired !== 4'd0) begin n_err++; $display("FAIL illegal_retired: got %0d want 0", retired); end
        zero = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        drive(LW, 3'b010, 1'b1);
        tick();
        idle();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (alu_src_e !== 1'b1 || mem_write_m !== 1'b0 || reg_write_m !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: got asrc_e=%b mw_m=%b rw_m=%b want 1 0 0",
                         i, alu_src_e, mem_write_m, reg_write_m);
            end
        end
        stall = 1'b0;
        tick();
        n_vec++;
        if (reg_write_m !== 1'b1 || result_src_m !== 2'b01 || alu_src_e !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: got rw_m=%b rs_m=%b asrc_e=%b want 1 01 0", reg_write_m, result_src_m, alu_src_e);
        end
        tick(); tick(); tick();
        n_vec++;
        if (retired !== 4'd1) begin n_err++; $display("FAIL stall_once: got %0d want 1", retired); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(JAL, 3'b000, 1'b1);
        tick();
        n_vec++;
        if (pc_src_e !== 1'b1) begin n_err++; $display("FAIL sf_jal_redirect: got %b want 1", pc_src_e); end
        drive(R, 3'b000, 1'b1);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        n_vec++;
        if (pc_src_e !== 1'b0 || alu_op_e !== 2'b00) begin
            n_err++; $display("FAIL sf_bubble: got pc_src=%b aop=%b want 0 00", pc_src_e, alu_op_e);
        end
        stall = 1'b0;
        flush = 1'b0;
        idle();
        repeat (4) tick();
        n_vec++;
        if (retired !== 4'd0) begin n_err++; $display("FAIL sf_retired: got %0d want 0", retired); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(ADDI, 3'b000, 1'b1);
            tick();
        end
        idle();
        repeat (3) tick();
        n_vec++;
        if (retired !== 4'd15) begin n_err++; $display("FAIL wrap_max: got %0d want 15", retired); end
        drive(ADDI, 3'b000, 1'b1);
        tick();
        idle();
        repeat (3) tick();
        n_vec++;
        if (retired !== 4'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", retired); end
    endtask

    task automatic test_reset_mid();
        logic [13:0] regs;
        do_reset();
        drive(R, 3'b000, 1'b1);  tick();
        drive(LW, 3'b010, 1'b1); tick();
        drive(SW, 3'b010, 1'b1); tick();
        drive(JAL, 3'b000, 1'b1);
        rst = 1'b1;
        tick();
        regs = {alu_op_e, alu_src_e, jalr_e, pc_src_e, mem_write_m, result_src_m,
                reg_write_m, result_src_w, reg_write_w, valid_w, 1'b0};
        n_vec++;
        if (regs !== 14'd0 || retired !== 4'd0) begin
            n_err++; $display("FAIL midreset_clear: got regs=%h retired=%0d want 0 0", regs, retired);
        end
        rst = 1'b0;
        drive(LUI, 3'b000, 1'b1);
        tick();
        n_vec++;
        if (alu_op_e !== 2'b11 || alu_src_e !== 1'b1) begin
            n_err++; $display("FAIL midreset_first: got aop=%b asrc=%b want 11 1", alu_op_e, alu_src_e);
        end
        idle();
        repeat (3) tick();
        n_vec++;
        if (retired !== 4'd1) begin n_err++; $display("FAIL midreset_retired: got %0d want 1", retired); end
    endtask

    initial begin
        test_reset();
        test_decode_table();
        test_stream();
        test_branch();
        test_illegal();
        test_stall();
        test_stall_flush();
        test_back_to_back();
        test_reset_mid();
        repeat (4) tick();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL sb_drain: %0d expected instructions never retired", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Parametrised successor to the combinational RV32I main decoder; adds sequential behaviour.
- Decodes opcode (plus funct3 for branches) in D.
- Carries the decoded control word through the ID/EX, EX/MEM and MEM/WB control registers, honouring hazard-unit stall/flush.
- Resolves branch/jump redirect in E, flags illegal opcodes, and counts retired instructions at W.

Parameters:
FULL_BRANCH, 1, 1 = decode beq/bne/blt/bge/bltu/bgeu via funct3; 0 = beq only, funct3 ignored
CNT_W, 32, width of retired-instruction counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_opcode_d  in  7  opcode of instruction in D
i_funct3_d  in  3  funct3 of instruction in D
i_valid_d  in  1  D holds a real instruction
i_stall_e  in  1  hold ID/EX register
i_flush_e  in  1  insert bubble into ID/EX
i_zero_e  in  1  ALU result == 0
i_lt_e  in  1  signed rs1 < rs2
i_ltu_e  in  1  unsigned rs1 < rs2
o_imm_src_d  out  3  combinational; extender select for D
o_illegal_d  out  1  combinational; unknown opcode or bad branch funct3 while i_valid_d
o_alu_op_e  out  2  ALU decoder class
o_alu_src_e  out  1  0 = rs2, 1 = imm
o_jalr_e  out  1  target = ALU result, not PC+imm
o_pc_src_e  out  1  combinational redirect request
o_mem_write_m  out  1  store enable
o_result_src_m  out  2  for load-use detection
o_reg_write_m  out  1  for forwarding
o_result_src_w  out  2  00 ALU, 01 mem, 10 PC+4
o_reg_write_w  out  1  register-file write enable
o_valid_w  out  1  W holds a real, legal instruction
o_retired  out  CNT_W  count of instructions leaving W with valid

Behaviour:
- Decode (combinational in D):
  - R: reg_write 1, alu_op 10.
  - LW: result 01, reg_write 1, alu_src 1, imm 000.
  - ADDI class: reg_write 1, alu_src 1, imm 000.
  - JALR: result 10, reg_write 1, jmp 1, jalr 1, alu_src 1, imm 000.
  - SW: mem_write 1, alu_src 1, imm 001.
  - JAL: result 10, reg_write 1, jmp 1, imm 011.
  - B: branch 1, alu_op 01, imm 010, funct3 latched.
  - LUI: reg_write 1, alu_op 11, alu_src 1, imm 100.
  - All unlisted fields are 0; this block emits no x values.
- Unknown opcode: all-zero control word and o_illegal_d=1.
- FULL_BRANCH=1 and branch funct3 010 or 011: all-zero control word and o_illegal_d=1.
- o_illegal_d is forced to 0 when i_valid_d=0.
- Control word registered in E: {result_src, mem_write, reg_write, jmp, branch, jalr, alu_op, alu_src, funct3, valid}. valid = i_valid_d & ~illegal.
- ID/EX update per edge:
  - i_rst: clear to 0.
  - else i_flush_e: load bubble (all 0). Flush wins over stall.
  - else i_stall_e: hold.
  - else: load decoded word.
- EX/MEM update: i_rst clears; i_stall_e loads a bubble (so a held E instruction is not duplicated); else copy E.
- MEM/WB update: i_rst clears; else copy M. No stall at M/W.
- Latency: D to o_*_e is 1 cycle, to M is 2, to W is 3.
- Branch condition in E:
  - FULL_BRANCH=0: taken = zero.
  - FULL_BRANCH=1, by funct3: 000 zero; 001 ~zero; 100 lt; 101 ~lt; 110 ltu; 111 ~ltu.
- o_pc_src_e = valid_e & (jmp_e | (branch_e & taken)). It is combinational from E register and flags. Bubbles never redirect.
- o_retired increments by 1 on each edge where o_valid_w=1. It wraps modulo 2^CNT_W and resets to 0.
- Reset: every registered output and o_retired = 0. Decode outputs follow inputs.
- Reset asserted mid-stream discards all in-flight control. The first post-reset instruction appears in E one cycle after reset deasserts.

Decomposition:
- Opcode constants (`OP_*`), result_src, imm_src and alu_op encodings, and branch funct3 codes live in the shared Constants.vh.
- One natural sub-module: main_decoder, the combinational opcode/funct3 to control word plus illegal logic. It is reused by future single-cycle variants.
- The pipeline registers, branch resolution and counter stay in control_unit_pipe.

Test Plan:
- Reset then stream: R, LW, SW, JAL → o_reg_write_w sequence 1,1,0,1 on cycles 3–6; o_result_src_w 00,01,xx-ignored,10; o_retired=3 after the SW leaves W (SW valid but no write; counts as 4 after JAL).
- BNE with i_zero_e=0, FULL_BRANCH=1 → o_pc_src_e=1 in that E cycle. Repeat with zero=1 → 0. With FULL_BRANCH=0, BNE funct3 with zero=1 → 1.
- Opcode 7'b1111111, i_valid_d=1 → o_illegal_d=1; E/M/W words all 0; o_valid_w=0; o_retired unchanged.
- LW in E with i_stall_e=1 for 2 cycles → E outputs held; M shows 2 bubbles (o_mem_write_m=0, o_reg_write_m=0); LW reaches W exactly once.
- i_stall_e=1 and i_flush_e=1 together → E becomes bubble next edge; o_pc_src_e=0 even when previous E was JAL.
- Preload o_retired to 2^CNT_W−1 (CNT_W=4: 15 instructions) then retire one more → o_retired=0. Assert i_rst mid-stream → all registered outputs 0 on next edge.
